// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART blocks.
// Holds the frame state encoding, the parity mode constants and a width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bits needed to hold 0..value-1, never less than one so counters stay declarable.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled and pulses tick on the terminal count.
// Shared between the transmitter and the planned receiver.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick || !en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, 5-8 data bits LSB first, optional parity,
// one or two stop bits, with a valid/ready input handshake and a registered serial line.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter combination");
  end

  localparam int               IDX_W     = clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [IDX_W-1:0]     idx;
  logic                 stop_cnt;
  logic                 tick;
  logic                 accept;

  assign ready  = (state == IDLE);
  assign accept = valid && ready;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  // tx is loaded on each transition with the level of the bit about to start,
  // so the line changes exactly on the bit-tick edge with no extra pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      idx      <= '0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= data_in;
            par_bit <= (PARITY == PAR_ODD) ? ~^data_in : ^data_in;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            idx   <= '0;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (PARITY != PAR_NONE) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state    <= STOP;
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
              tx  <= shreg[1];
            end
          end
        end
        PAR: begin
          if (tick) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              state    <= IDLE;
              busy     <= 1'b0;
              stop_cnt <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter that supersedes the fixed 8N1 bit-per-clock transmitter. It adds a baud-rate divider, configurable data width, optional parity, one or two stop bits, and a valid/ready input handshake. It sits between a byte-stream producer (FIFO or register interface) and the serial pin.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `DATA_BITS`, default 8: payload bits per frame; legal range 5–8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_BITS  payload word; sampled only on accept.
- `valid`  in  1  producer has a word.
- `ready`  out  1  transmitter can accept a word.
- `tx`  out  1  serial line, registered; idles high.
- `busy`  out  1  a frame is in progress.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Accept: `valid && ready` at a rising edge latches `data_in` into the shift register and enters START.
- `ready` = (state == IDLE), combinational from state. `valid` without `ready` is ignored; the producer holds `data_in` until accepted.
- Baud counter runs 0..CLK_DIV-1 in every non-IDLE state. The terminal count is the bit tick; the counter is cleared on accept and on each tick.
- START: `tx` = 0. On tick → DATA, bit index = 0.
- DATA: `tx` = shift-register LSB (LSB first). On tick, shift right and increment index. After index DATA_BITS-1 → PAR if PARITY≠0, else STOP.
- PAR: `tx` = XOR of the latched word for even parity, its inverse for odd parity. Parity is computed at accept and held in a register. On tick → STOP.
- STOP: `tx` = 1 for STOP_BITS bit periods, tracked by a stop counter. On final tick → IDLE.
- `busy` = registered (state ≠ IDLE).
- Frame length: F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
- Width rules:
  - Baud counter width = clog2(CLK_DIV).
  - Bit index width = clog2(DATA_BITS).
  - Counters never wrap inside a state; each is cleared on state change.
- Reset: `tx` = 1, `busy` = 0, state = IDLE, counters = 0. `ready` = 1 from the first cycle after `rst` deasserts. Reset mid-frame aborts immediately: `tx` is high on the cycle after the reset edge, and no partial stop bit is emitted.
- `valid` asserted during `rst` is not accepted.
- Illegal parameters (PARITY > 2, STOP_BITS ∉ {1, 2}, CLK_DIV < 2) are flagged by an elaboration-time check.

## Timing
- Accept at edge k: `tx` falls and `busy` rises after edge k. START occupies cycles k+1..k+CLK_DIV.
- Each bit holds `tx` for exactly CLK_DIV cycles; there is no jitter.
- Last stop bit ends at edge k+F. The state returns to IDLE there, so `ready` = 1 in cycle k+F+1, and `busy` falls after edge k+F.
- Back-to-back: with `valid` held high, the next accept happens at edge k+F+1. This gives one idle-high clock between frames, so throughput is one word per F+1 cycles.
- `data_in` changes after accept do not affect the frame in flight.

## Structure
- Package `uart_pkg`:
  - State typedef (IDLE, START, DATA, PAR, STOP).
  - Parity constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - clog2 helper.
- Sub-module `uart_baud_tick`:
  - Parameter CLK_DIV; inputs `clk`, `rst`, `clear`, `en`; output `tick`.
  - Reusable by the future receiver.
- The top FSM, shift register, parity register and stop counter live in `uart_tx_cfg`.

## Test plan
- Defaults (CLK_DIV 16, 8N1); send 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles. `busy` high for 160 cycles; `ready` returns at cycle 161.
- CLK_DIV 4, DATA_BITS 7, PARITY even, STOP_BITS 2; send 0x53 (four ones) → start 0, data 1,1,0,0,1,0,1, parity 0, stop 1,1. Total 44 cycles.
- Same configuration with PARITY odd; send 0x00 → parity bit 1.
- `valid` held high with words 0x01, 0x02, 0x03 → three frames, each separated by exactly one idle-high clock. No word is dropped or duplicated, and `ready` is never high while `busy` is high.
- Assert `rst` for one cycle midway through the data bits of 0xFF → `tx` = 1 and `busy` = 0 on the next cycle. A new word (0x0F) accepted afterwards transmits correctly.
- Toggle `valid` while `busy` and change `data_in` mid-frame → no extra accepts, and the in-flight frame is unchanged.
